// File: rtl/eth_mac_xgmii_tx_10g.sv
// 10G MAC XGMII transmit encoder: frame stream to 64-bit XGMII words.
// Adds start/preamble, terminate and minimum IFG; paced by the PCS enable.
module eth_mac_xgmii_tx_10g #(
  parameter int N_CHANNELS = 8,
  parameter int W_BYTE     = 8
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_clk_en,
  input  logic [N_CHANNELS*W_BYTE-1:0] i_s_data,
  input  logic [N_CHANNELS-1:0]        i_s_keep,
  input  logic                         i_s_last,
  input  logic                         i_s_valid,
  output logic                         o_s_ready,
  output logic [N_CHANNELS-1:0]        o_xgmii_ctrl,
  output logic [N_CHANNELS*W_BYTE-1:0] o_xgmii_data,
  output logic                         o_err_underflow
);

  localparam int DW = N_CHANNELS * W_BYTE;
  localparam int KW = $clog2(N_CHANNELS + 1);

  localparam logic [W_BYTE-1:0] C_IDLE  = W_BYTE'(8'h07);
  localparam logic [W_BYTE-1:0] C_START = W_BYTE'(8'hFB);
  localparam logic [W_BYTE-1:0] C_TERM  = W_BYTE'(8'hFD);
  localparam logic [W_BYTE-1:0] C_ERR   = W_BYTE'(8'hFE);
  localparam logic [W_BYTE-1:0] C_PRE   = W_BYTE'(8'h55);
  localparam logic [W_BYTE-1:0] C_SFD   = W_BYTE'(8'hD5);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_TERM  = 3'd2;
  localparam logic [2:0] S_ABORT = 3'd3;
  localparam logic [2:0] S_DROP  = 3'd4;
  localparam logic [2:0] S_IFG   = 3'd5;

  localparam logic [DW-1:0] W_IDLE =
    {N_CHANNELS{C_IDLE}};
  localparam logic [DW-1:0] W_ERR =
    {N_CHANNELS{C_ERR}};
  localparam logic [DW-1:0] W_TERM =
    {{(N_CHANNELS-1){C_IDLE}}, C_TERM};
  localparam logic [DW-1:0] W_START =
    {C_SFD, {(N_CHANNELS-2){C_PRE}}, C_START};

  logic [2:0]            state_q, state_d;
  logic [N_CHANNELS-1:0] ctrl_q, ctrl_d;
  logic [DW-1:0]         data_q, data_d;
  logic                  two_q, two_d;
  logic                  err_q, err_d;

  logic [N_CHANNELS-1:0] term_m;
  logic [DW-1:0]         last_data;
  logic [KW-1:0]         kcnt;
  logic                  few_idle;

  // Partial last beat: data lanes, then terminate, then idle fill.
  always_comb begin
    term_m = ~i_s_keep & {i_s_keep[N_CHANNELS-2:0], 1'b1};
    kcnt = '0;
    last_data = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      kcnt = kcnt + KW'(i_s_keep[i]);
      unique case (1'b1)
        i_s_keep[i]:
          last_data[i*W_BYTE +: W_BYTE] =
            i_s_data[i*W_BYTE +: W_BYTE];
        term_m[i]:
          last_data[i*W_BYTE +: W_BYTE] = C_TERM;
        default:
          last_data[i*W_BYTE +: W_BYTE] = C_IDLE;
      endcase
    end
    few_idle = (N_CHANNELS - 1 - int'(kcnt)) < 4;
  end

  assign o_s_ready = i_clk_en &&
    (state_q == S_DATA || state_q == S_DROP);

  always_comb begin
    state_d = state_q;
    ctrl_d  = '1;
    data_d  = W_IDLE;
    two_d   = two_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_s_valid) begin
          ctrl_d  = N_CHANNELS'(1);
          data_d  = W_START;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!i_s_valid) begin
          data_d  = W_ERR;
          err_d   = 1'b1;
          state_d = S_ABORT;
        end else if (i_s_last && !(&i_s_keep)) begin
          ctrl_d  = ~i_s_keep;
          data_d  = last_data;
          two_d   = few_idle;
          state_d = S_IFG;
        end else begin
          ctrl_d = '0;
          data_d = i_s_data;
          if (i_s_last) state_d = S_TERM;
        end
      end
      S_TERM: begin
        data_d  = W_TERM;
        two_d   = 1'b0;
        state_d = S_IFG;
      end
      S_ABORT: begin
        data_d  = W_TERM;
        state_d = S_DROP;
      end
      S_DROP: begin
        if (i_s_valid && i_s_last) begin
          two_d   = 1'b0;
          state_d = S_IFG;
        end
      end
      S_IFG: begin
        if (two_q) two_d = 1'b0;
        else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The underflow flag is cleared on every clock so it spans one cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '1;
      data_q  <= W_IDLE;
      two_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (i_clk_en) begin
        state_q <= state_d;
        ctrl_q  <= ctrl_d;
        data_q  <= data_d;
        two_q   <= two_d;
        err_q   <= err_d;
      end
    end
  end

  assign o_xgmii_ctrl    = ctrl_q;
  assign o_xgmii_data    = data_q;
  assign o_err_underflow = err_q;

endmodule

// File: tb/tb_eth_mac_xgmii_tx_10g.sv
// Bench for eth_mac_xgmii_tx_10g: random frames vs a byte-lane model.
// Model serialises each frame to lanes and pads idles to >=12 bytes.
module tb_eth_mac_xgmii_tx_10g;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic [63:0] s_data = '0;
  logic [7:0]  s_keep = '0;
  logic        s_last = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  x_ctrl;
  logic [63:0] x_data;
  logic        err_uf;

  eth_mac_xgmii_tx_10g dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_clk_en        (clk_en),
    .i_s_data        (s_data),
    .i_s_keep        (s_keep),
    .i_s_last        (s_last),
    .i_s_valid       (s_valid),
    .o_s_ready       (s_ready),
    .o_xgmii_ctrl    (x_ctrl),
    .o_xgmii_data    (x_data),
    .o_err_underflow (err_uf)
  );

  always #5 clk = ~clk;

  localparam logic [71:0] W_IDLE  = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] W_START = {8'h01, 64'hD5555555555555FB};
  localparam logic [71:0] W_ERR   = {8'hFF, 64'hFEFEFEFEFEFEFEFE};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  logic [8:0]  lanes[$];
  logic [71:0] exp_q[$];
  logic [7:0]  pay[$];
  int          f_len[$];
  int          f_uf[$];

  function automatic void push_lane(input bit c, input logic [7:0] b);
    lanes.push_back({c, b});
  endfunction

  function automatic void idle_word();
    for (int i = 0; i < 8; i++) push_lane(1'b1, 8'h07);
  endfunction

  // Whole idle words until at least 12 idle bytes follow the terminate.
  function automatic void close_ifg(input int r);
    int idl;
    idl = r;
    while (idl < 12) begin
      idle_word();
      idl += 8;
    end
  endfunction

  function automatic void add_frame(input int len, input int uf);
    int base, r, nb;
    base = pay.size();
    nb = (len + 7) / 8;
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    f_len.push_back(len);
    f_uf.push_back(uf);
    push_lane(1'b1, 8'hFB);
    for (int i = 0; i < 6; i++) push_lane(1'b0, 8'h55);
    push_lane(1'b0, 8'hD5);
    if (uf <= 0) begin
      for (int i = 0; i < len; i++) push_lane(1'b0, pay[base+i]);
      push_lane(1'b1, 8'hFD);
      r = 0;
      while (lanes.size() % 8 != 0) begin
        push_lane(1'b1, 8'h07);
        r++;
      end
      close_ifg(r);
    end else begin
      for (int i = 0; i < uf * 8; i++) push_lane(1'b0, pay[base+i]);
      for (int i = 0; i < 8; i++) push_lane(1'b1, 8'hFE);
      push_lane(1'b1, 8'hFD);
      for (int i = 0; i < 7; i++) push_lane(1'b1, 8'h07);
      for (int i = uf; i < nb; i++) idle_word();
      close_ifg(7);
    end
  endfunction

  function automatic void build_exp();
    logic [71:0] w;
    exp_q.delete();
    for (int i = 0; i < 4; i++) idle_word();
    for (int k = 0; k < lanes.size() / 8; k++) begin
      for (int i = 0; i < 8; i++) begin
        w[64+i]    = lanes[8*k+i][8];
        w[8*i +: 8] = lanes[8*k+i][7:0];
      end
      exp_q.push_back(w);
    end
  endfunction

  function automatic void clear_frames();
    lanes.delete();
    pay.delete();
    f_len.delete();
    f_uf.delete();
  endfunction

  int  fi, bj, base, cyc;
  bit  gap_done, gap_now, acc, armed, en_last;

  function automatic bit pick_en(input int mode, input int c);
    case (mode)
      0: return 1'b1;
      1: return (c % 33) != 32;
      default: return ($urandom % 6) != 0;
    endcase
  endfunction

  task automatic present();
    int len, nb, idx;
    if (fi < f_len.size() && !gap_now) begin
      len = f_len[fi];
      nb = (len + 7) / 8;
      s_valid = 1'b1;
      s_last = (bj == nb - 1);
      for (int i = 0; i < 8; i++) begin
        idx = 8 * bj + i;
        s_keep[i] = idx < len;
        s_data[8*i +: 8] = (idx < len) ? pay[base+idx]
                                       : 8'($urandom);
      end
    end else begin
      s_valid = 1'b0;
      s_last = 1'($urandom);
      s_keep = 8'($urandom);
      s_data = {$urandom, $urandom};
    end
  endtask

  task automatic step_drive(input int mode);
    if (acc) begin
      bj++;
      if (bj == (f_len[fi] + 7) / 8) begin
        base += f_len[fi];
        fi++;
        bj = 0;
        gap_done = 1'b0;
      end
    end
    en_last = clk_en;
    gap_now = fi < f_len.size() && f_uf[fi] > 0 &&
              bj == f_uf[fi] && !gap_done;
    if (gap_now) begin
      gap_done = 1'b1;
      clk_en = 1'b1;
    end else begin
      clk_en = pick_en(mode, cyc);
    end
    present();
  endtask

  // Drives the queued frames and checks every enabled word in order.
  task automatic run_stream(input int mode);
    logic [71:0] word, prev, exp;
    build_exp();
    fi = 0; bj = 0; base = 0; cyc = 0;
    gap_done = 1'b0; acc = 1'b0; armed = 1'b0;
    @(posedge clk); #1;
    step_drive(mode);
    prev = {x_ctrl, x_data};
    while (cyc < 20000 && !(armed && exp_q.size() == 0)) begin
      @(negedge clk);
      word = {x_ctrl, x_data};
      if (!armed && en_last && word == W_START) armed = 1'b1;
      if (armed && en_last && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        chk("word", word, exp);
        chk("uflow", 72'(err_uf), 72'(exp == W_ERR));
      end else if (armed && !en_last) begin
        chk("hold", word, prev);
        chk("uflow_hold", 72'(err_uf), 72'(0));
      end
      if (!clk_en) chk("rdy_stall", 72'(s_ready), 72'(0));
      prev = word;
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      cyc++;
      step_drive(mode);
    end
    chk("drain", 72'(exp_q.size()), 72'(0));
    clear_frames();
  endtask

  initial begin
    int len, nb;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      clk_en = 1'($urandom);
      s_valid = 1'($urandom);
      s_last = 1'($urandom);
      s_keep = 8'($urandom);
      s_data = {$urandom, $urandom};
      @(negedge clk);
      chk("rst_word", {x_ctrl, x_data}, W_IDLE);
      chk("rst_rdy", 72'(s_ready), 72'(0));
      chk("rst_uf", 72'(err_uf), 72'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clk_en = 1'b1;
    s_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_word", {x_ctrl, x_data}, W_IDLE);
      chk("post_rst_rdy", 72'(s_ready), 72'(0));
    end

    foreach (f_len[i]) f_len.delete();
    add_frame(64, 0);
    add_frame(61, 0);
    add_frame(64, 0);
    add_frame(63, 0);
    add_frame(63, 0);
    add_frame(60, 0);
    add_frame(59, 0);
    add_frame(57, 0);
    add_frame(58, 0);
    add_frame(62, 0);
    add_frame(64, 3);
    add_frame(64, 0);
    add_frame(9, 0);
    add_frame(1500, 0);
    run_stream(0);

    add_frame(1500, 0);
    add_frame(64, 0);
    add_frame(61, 0);
    add_frame(64, 3);
    add_frame(63, 0);
    run_stream(1);

    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 200);
      nb = (len + 7) / 8;
      if (nb >= 2 && ($urandom % 5) == 0)
        add_frame(len, $urandom_range(1, nb - 1));
      else
        add_frame(len, 0);
    end
    run_stream(2);

    @(posedge clk); #1;
    clk_en = 1'b1;
    s_valid = 1'b1;
    s_keep = 8'hFF;
    s_last = 1'b0;
    s_data = {$urandom, $urandom};
    repeat (4) @(posedge clk);
    #3;
    chk("mid_ctrl", 72'(x_ctrl), 72'(0));
    chk("mid_data", 72'(x_data), 72'(s_data));
    rst_n = 1'b0;
    #1;
    chk("async_rst_word", {x_ctrl, x_data}, W_IDLE);
    chk("async_rst_rdy", 72'(s_ready), 72'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("after_rst_word", {x_ctrl, x_data}, W_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
